// File: rtl/bram_dwc_pkg.sv
// Shared types and elaboration helpers for the serial BRAM data-width converter.
//
// Contents:
//   dwcState_t - converter FSM states (IDLE, WRITE, READ, DRAIN)
//   ratio      - number of slave beats per master access
//   clog2      - ceiling log2 for constant expressions
//   idxBitw    - beat-index width, never less than one bit
//   beBitw     - byte-enable width of a data bus
package bram_dwc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } dwcState_t;

   function automatic int ratio(input int mstBitw, input int slvBitw);
      return mstBitw / slvBitw;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // An N=1 converter still needs a one-bit index so every vector stays legal.
   function automatic int idxBitw(input int numBeats);
      return (numBeats > 1) ? clog2(numBeats) : 1;
   endfunction

   function automatic int beBitw(input int dataBitw);
      return dataBitw / 8;
   endfunction

endpackage

// File: rtl/bram_dwc_rd_tracker.sv
// Read-tag pipeline for the serial BRAM data-width converter.
// Carries (valid, beat index) for each issued read beat through LATENCY
// stages so the tag emerges in the same cycle as the BRAM read data.
//
// Ports:
//   Clk_CI          clock
//   Rst_RBI         asynchronous active-low reset, clears all tags
//   IssueValid_SI   a read beat is on the BRAM port this cycle
//   IssueIdx_SI     beat index of that read beat
//   TagValid_SO     read data for beat TagIdx_SO is on BramRd_DI this cycle
//   TagIdx_SO       beat index of the emerging tag
//   LastCapture_SO  emerging tag belongs to the final beat
module bram_dwc_rd_tracker #(
   parameter int LATENCY   = 1,
   parameter int NUM_BEATS = 4,
   parameter int IDX_BITW  = 2
) (
   input  logic                Clk_CI,
   input  logic                Rst_RBI,
   input  logic                IssueValid_SI,
   input  logic [IDX_BITW-1:0] IssueIdx_SI,
   output logic                TagValid_SO,
   output logic [IDX_BITW-1:0] TagIdx_SO,
   output logic                LastCapture_SO
);

   localparam logic [IDX_BITW-1:0] LAST_IDX = IDX_BITW'(NUM_BEATS - 1);

   logic                validQ [LATENCY];
   logic [IDX_BITW-1:0] idxQ   [LATENCY];

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int i = 0; i < LATENCY; i++) begin
            validQ[i] <= 1'b0;
            idxQ[i]   <= '0;
         end
      end else begin
         validQ[0] <= IssueValid_SI;
         idxQ[0]   <= IssueIdx_SI;
         for (int i = 1; i < LATENCY; i++) begin
            validQ[i] <= validQ[i-1];
            idxQ[i]   <= idxQ[i-1];
         end
      end
   end

   assign TagValid_SO    = validQ[LATENCY-1];
   assign TagIdx_SO      = idxQ[LATENCY-1];
   assign LastCapture_SO = validQ[LATENCY-1] && (idxQ[LATENCY-1] == LAST_IDX);

endmodule

// File: rtl/bram_dwc_serial.sv
// Sequential BRAM data-width converter: a wide master port serialised onto a
// narrow BRAM slave port, N = MST_DATA_BITW/SLV_DATA_BITW beats per access.
// Read beats are reassembled into one wide word.
//
// Optional feature: define BRAM_DWC_SKIP_EMPTY_EN to skip write beats whose
// byte-enable slice is all zero; otherwise every beat takes its cycle.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, asynchronous active-low reset
//   Req_SI/Gnt_SO            master request / combinational grant
//   Addr_SI, WrEn_SI, Wr_DI  master byte address, byte enables (0 = read), data
//   RdValid_SO, Rd_DO        one-cycle read-done pulse, assembled read word
//   Busy_SO                  FSM not IDLE
//   BramEn_SO, BramAddr_SO, BramWrEn_SO, BramWr_DO, BramRd_DI  slave port
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access in flight, grant possible
// WRITE | issuing write beats, one per cycle
// READ  | issuing read beats, one per cycle
// DRAIN | waiting for the final read beat's data to return
module bram_dwc_serial
   import bram_dwc_pkg::*;
#(
   parameter int ADDR_BITW     = 32,
   parameter int MST_DATA_BITW = 128,
   parameter int SLV_DATA_BITW = 32,
   parameter int RD_LATENCY    = 1
) (
   input  logic                       Clk_CI,
   input  logic                       Rst_RBI,
   input  logic                       Req_SI,
   output logic                       Gnt_SO,
   input  logic [ADDR_BITW-1:0]       Addr_SI,
   input  logic [MST_DATA_BITW/8-1:0] WrEn_SI,
   input  logic [MST_DATA_BITW-1:0]   Wr_DI,
   output logic                       RdValid_SO,
   output logic [MST_DATA_BITW-1:0]   Rd_DO,
   output logic                       Busy_SO,
   output logic                       BramEn_SO,
   output logic [ADDR_BITW-1:0]       BramAddr_SO,
   output logic [SLV_DATA_BITW/8-1:0] BramWrEn_SO,
   output logic [SLV_DATA_BITW-1:0]   BramWr_DO,
   input  logic [SLV_DATA_BITW-1:0]   BramRd_DI
);

   localparam int N        = ratio(MST_DATA_BITW, SLV_DATA_BITW);
   localparam int IDX_BITW = idxBitw(N);
   localparam int MST_BE   = beBitw(MST_DATA_BITW);
   localparam int SLV_BE   = beBitw(SLV_DATA_BITW);
   localparam logic [ADDR_BITW-1:0] ALIGN_MASK = ~ADDR_BITW'(MST_BE - 1);
   localparam logic [IDX_BITW-1:0]  LAST_IDX   = IDX_BITW'(N - 1);

   if (MST_DATA_BITW % SLV_DATA_BITW != 0) begin : gBadRatio
      $fatal(1, "MST_DATA_BITW must be a multiple of SLV_DATA_BITW");
   end
   if ((MST_DATA_BITW % 8 != 0) || (SLV_DATA_BITW % 8 != 0)) begin : gBadBytes
      $fatal(1, "data widths must be multiples of 8");
   end
   if (RD_LATENCY < 1) begin : gBadLatency
      $fatal(1, "RD_LATENCY must be at least 1");
   end

   dwcState_t stateQ, stateD;

   logic [IDX_BITW-1:0]      kQ;
   logic [ADDR_BITW-1:0]     addrQ;
   logic [MST_BE-1:0]        wrEnQ;
   logic [MST_DATA_BITW-1:0] wrDQ;

   logic                     bramEnQ;
   logic [ADDR_BITW-1:0]     bramAddrQ;
   logic [SLV_BE-1:0]        bramWeQ;
   logic [SLV_DATA_BITW-1:0] bramWrDQ;

   logic [ADDR_BITW-1:0]     srcAddr;
   logic [MST_BE-1:0]        srcWrEn;
   logic [MST_DATA_BITW-1:0] srcWrD;

   logic                     grant;
   logic                     issue;
   logic                     issueWr;
   logic [IDX_BITW-1:0]      issueIdx;
   logic                     issueEn;
   logic [SLV_BE-1:0]        issueWe;
   logic [SLV_BE-1:0]        weSlice;

   logic                     tagValid;
   logic [IDX_BITW-1:0]      tagIdx;
   logic                     lastCap;
   logic [MST_DATA_BITW-1:0] rdBufQ;
   logic [MST_DATA_BITW-1:0] rdMerged;
   logic [MST_DATA_BITW-1:0] rdDQ;
   logic                     rdValidQ;

`ifdef BRAM_DWC_SKIP_EMPTY_EN
   logic [IDX_BITW:0] nz;

   // Lowest beat index >= start with a non-empty enable slice; MSB = found.
   function automatic logic [IDX_BITW:0] findNz(input logic [MST_BE-1:0] be, input int start);
      logic [IDX_BITW:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if ((i >= start) && (be[i*SLV_BE +: SLV_BE] != '0)) r = {1'b1, IDX_BITW'(i)};
      end
      return r;
   endfunction
`endif

   // In IDLE the first beat is launched straight from the master inputs;
   // later beats come from the copy registered at grant.
   always_comb begin
      srcAddr = addrQ;
      srcWrEn = wrEnQ;
      srcWrD  = wrDQ;
      if (stateQ == IDLE) begin
         srcAddr = Addr_SI & ALIGN_MASK;
         srcWrEn = WrEn_SI;
         srcWrD  = Wr_DI;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) stateQ <= IDLE;
      else          stateQ <= stateD;
   end

   always_comb begin
      stateD   = stateQ;
      grant    = 1'b0;
      issue    = 1'b0;
      issueWr  = 1'b0;
      issueIdx = kQ;
`ifdef BRAM_DWC_SKIP_EMPTY_EN
      nz       = '0;
`endif
      unique case (stateQ)
         IDLE: begin
            grant = Req_SI;
            if (Req_SI) begin
               issue = 1'b1;
               if (WrEn_SI != '0) begin
                  stateD  = WRITE;
                  issueWr = 1'b1;
`ifdef BRAM_DWC_SKIP_EMPTY_EN
                  nz       = findNz(WrEn_SI, 0);
                  issueIdx = nz[IDX_BITW-1:0];
`else
                  issueIdx = '0;
`endif
               end else begin
                  stateD   = READ;
                  issueIdx = '0;
               end
            end
         end
         WRITE: begin
`ifdef BRAM_DWC_SKIP_EMPTY_EN
            nz = findNz(wrEnQ, int'(kQ) + 1);
            if (nz[IDX_BITW]) begin
               issue    = 1'b1;
               issueWr  = 1'b1;
               issueIdx = nz[IDX_BITW-1:0];
            end else begin
               stateD = IDLE;
            end
`else
            if (kQ == LAST_IDX) begin
               stateD = IDLE;
            end else begin
               issue    = 1'b1;
               issueWr  = 1'b1;
               issueIdx = kQ + IDX_BITW'(1);
            end
`endif
         end
         READ: begin
            if (kQ == LAST_IDX) begin
               stateD = DRAIN;
            end else begin
               issue    = 1'b1;
               issueIdx = kQ + IDX_BITW'(1);
            end
         end
         DRAIN: begin
            if (lastCap) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase

      weSlice = srcWrEn[int'(issueIdx)*SLV_BE +: SLV_BE];
      issueWe = issueWr ? weSlice : '0;
      // A write beat with an empty enable slice still occupies its cycle
      // but leaves the BRAM disabled.
      issueEn = issueWr ? (weSlice != '0) : issue;
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         kQ        <= '0;
         addrQ     <= '0;
         wrEnQ     <= '0;
         wrDQ      <= '0;
         bramEnQ   <= 1'b0;
         bramAddrQ <= '0;
         bramWeQ   <= '0;
         bramWrDQ  <= '0;
      end else begin
         if (grant) begin
            addrQ <= srcAddr;
            wrEnQ <= WrEn_SI;
            wrDQ  <= Wr_DI;
         end
         if (issue) begin
            kQ        <= issueIdx;
            bramAddrQ <= srcAddr + ADDR_BITW'(int'(issueIdx) * SLV_BE);
            bramWrDQ  <= srcWrD[int'(issueIdx)*SLV_DATA_BITW +: SLV_DATA_BITW];
         end
         bramEnQ <= issueEn;
         bramWeQ <= issueWe;
      end
   end

   bram_dwc_rd_tracker #(
      .LATENCY   (RD_LATENCY),
      .NUM_BEATS (N),
      .IDX_BITW  (IDX_BITW)
   ) i_rdTracker (
      .Clk_CI         (Clk_CI),
      .Rst_RBI        (Rst_RBI),
      .IssueValid_SI  (bramEnQ && (stateQ == READ)),
      .IssueIdx_SI    (kQ),
      .TagValid_SO    (tagValid),
      .TagIdx_SO      (tagIdx),
      .LastCapture_SO (lastCap)
   );

   always_comb begin
      rdMerged = rdBufQ;
      rdMerged[int'(tagIdx)*SLV_DATA_BITW +: SLV_DATA_BITW] = BramRd_DI;
   end

   // The final slice is merged on its way into Rd_DO so the word is
   // published the cycle after the last data beat.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         rdBufQ   <= '0;
         rdDQ     <= '0;
         rdValidQ <= 1'b0;
      end else begin
         if (tagValid) rdBufQ <= rdMerged;
         if (lastCap)  rdDQ   <= rdMerged;
         rdValidQ <= lastCap;
      end
   end

   assign Gnt_SO      = grant;
   assign Busy_SO     = (stateQ != IDLE);
   assign BramEn_SO   = bramEnQ;
   assign BramAddr_SO = bramAddrQ;
   assign BramWrEn_SO = bramWeQ;
   assign BramWr_DO   = bramWrDQ;
   assign RdValid_SO  = rdValidQ;
   assign Rd_DO       = rdDQ;

endmodule

// File: tb/tb_bram_dwc_serial.sv
module tb_bram_dwc_serial;

   localparam logic [127:0] DATA_A = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] DATA_W = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] DATA_E = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;

   logic         clk;
   logic         rst_n;

   logic         req, gnt, rv, busy, bEn;
   logic [31:0]  addr, bAddr, bWd, bRd;
   logic [15:0]  wrEn;
   logic [127:0] wrD, rdD;
   logic [3:0]   bWe;

   logic         req3, gnt3, rv3, busy3, bEn3;
   logic [31:0]  addr3, bAddr3, bWd3, bRd3;
   logic [15:0]  wrEn3;
   logic [127:0] wrD3, rdD3;
   logic [3:0]   bWe3;

   int checks;
   int failures;

   bram_dwc_serial #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32), .RD_LATENCY(1)) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt), .Addr_SI(addr),
      .WrEn_SI(wrEn), .Wr_DI(wrD), .RdValid_SO(rv), .Rd_DO(rdD), .Busy_SO(busy),
      .BramEn_SO(bEn), .BramAddr_SO(bAddr), .BramWrEn_SO(bWe), .BramWr_DO(bWd),
      .BramRd_DI(bRd)
   );

   bram_dwc_serial #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32), .RD_LATENCY(3)) dut3 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req3), .Gnt_SO(gnt3), .Addr_SI(addr3),
      .WrEn_SI(wrEn3), .Wr_DI(wrD3), .RdValid_SO(rv3), .Rd_DO(rdD3), .Busy_SO(busy3),
      .BramEn_SO(bEn3), .BramAddr_SO(bAddr3), .BramWrEn_SO(bWe3), .BramWr_DO(bWd3),
      .BramRd_DI(bRd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM slave models: latency 1 and latency 3
   logic [31:0] mem  [16];
   logic [31:0] mem3 [16];
   logic [31:0] r3a, r3b, r3c;

   always @(posedge clk) begin
      if (bEn) begin
         for (int b = 0; b < 4; b++)
            if (bWe[b]) mem[bAddr[5:2]][b*8 +: 8] <= bWd[b*8 +: 8];
         bRd <= mem[bAddr[5:2]];
      end
   end

   always @(posedge clk) begin
      if (bEn3) begin
         for (int b = 0; b < 4; b++)
            if (bWe3[b]) mem3[bAddr3[5:2]][b*8 +: 8] <= bWd3[b*8 +: 8];
         r3a <= mem3[bAddr3[5:2]];
      end
      r3b <= r3a;
      r3c <= r3b;
   end
   assign bRd3 = r3c;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic         req;
      logic [31:0]  addr;
      logic [15:0]  we;
      logic [127:0] wd;
      logic         gnt;
      logic         busy;
      logic         en;
      logic [31:0]  bAddr;
      logic [3:0]   bWe;
      logic [31:0]  bWd;
      logic         rv;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rvSeen;
      int beatJ;
      logic expEn, expBusy;

      checks = 0;
      failures = 0;

      // Back-to-back: write (grant A) then read held on the same request (grant A+5)
      vecs[0]  = '{1'b1, 32'h10, 16'hFFFF, DATA_A, 1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 32'h13, 16'h0000, DATA_A, 1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h11111111, 1'b0};
      vecs[2]  = '{1'b1, 32'h13, 16'h0000, DATA_A, 1'b0, 1'b1, 1'b1, 32'h14, 4'hF, 32'h22222222, 1'b0};
      vecs[3]  = '{1'b1, 32'h13, 16'h0000, DATA_A, 1'b0, 1'b1, 1'b1, 32'h18, 4'hF, 32'h33333333, 1'b0};
      vecs[4]  = '{1'b1, 32'h13, 16'h0000, DATA_A, 1'b0, 1'b1, 1'b1, 32'h1C, 4'hF, 32'h44444444, 1'b0};
      vecs[5]  = '{1'b1, 32'h13, 16'h0000, DATA_A, 1'b1, 1'b0, 1'b0, 32'h1C, 4'h0, 32'h44444444, 1'b0};
      vecs[6]  = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h11111111, 1'b0};
      vecs[7]  = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b1, 1'b1, 32'h14, 4'h0, 32'h22222222, 1'b0};
      vecs[8]  = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b1, 1'b1, 32'h18, 4'h0, 32'h33333333, 1'b0};
      vecs[9]  = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b1, 1'b1, 32'h1C, 4'h0, 32'h44444444, 1'b0};
      vecs[10] = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b1, 1'b0, 32'h1C, 4'h0, 32'h44444444, 1'b0};
      vecs[11] = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b0, 1'b0, 32'h1C, 4'h0, 32'h44444444, 1'b1};
      vecs[12] = '{1'b0, 32'h0,  16'h0000, 128'h0, 1'b0, 1'b0, 1'b0, 32'h1C, 4'h0, 32'h44444444, 1'b0};

      rst_n = 1'b0;
      req = 1'b0;  addr = '0;  wrEn = '0;  wrD = '0;
      req3 = 1'b0; addr3 = '0; wrEn3 = '0; wrD3 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset.gnt", gnt, 0);
      chk("reset.busy", busy, 0);
      chk("reset.en", bEn, 0);
      chk("reset.addr", bAddr, 0);
      chk("reset.we", bWe, 0);
      chk("reset.wd", bWd, 0);
      chk("reset.rv", rv, 0);
      chk("reset.rd", rdD, 0);
      chk("reset.busy3", busy3, 0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         req = vecs[i].req; addr = vecs[i].addr; wrEn = vecs[i].we; wrD = vecs[i].wd;
         #1;
         chk($sformatf("vec%0d.gnt", i),   gnt,   vecs[i].gnt);
         chk($sformatf("vec%0d.busy", i),  busy,  vecs[i].busy);
         chk($sformatf("vec%0d.en", i),    bEn,   vecs[i].en);
         chk($sformatf("vec%0d.addr", i),  bAddr, vecs[i].bAddr);
         chk($sformatf("vec%0d.we", i),    bWe,   vecs[i].bWe);
         chk($sformatf("vec%0d.wd", i),    bWd,   vecs[i].bWd);
         chk($sformatf("vec%0d.rv", i),    rv,    vecs[i].rv);
         if (vecs[i].rv) chk($sformatf("vec%0d.rd", i), rdD, DATA_A);
      end
      chk("hold.rd", rdD, DATA_A);

      // Sparse write, enables only in slice 1
      @(negedge clk);
      req = 1'b1; addr = 32'h20; wrEn = 16'h00F0; wrD = DATA_W;
      #1;
      chk("sparse.gnt", gnt, 1);
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         req = 1'b0; wrEn = '0;
         #1;
`ifdef BRAM_DWC_SKIP_EMPTY_EN
         expEn = (j == 1); expBusy = (j == 1); beatJ = 1;
`else
         expEn = (j == 2); expBusy = (j <= 4); beatJ = 2;
`endif
         chk($sformatf("sparse%0d.en", j), bEn, expEn);
         chk($sformatf("sparse%0d.busy", j), busy, expBusy);
         if (j == beatJ) begin
            chk("sparse.addr", bAddr, 32'h24);
            chk("sparse.we", bWe, 4'hF);
            chk("sparse.wd", bWd, 32'hBBBBBBBB);
         end
      end

      // Reset in the middle of a read
      @(negedge clk);
      req = 1'b1; addr = 32'h13; wrEn = '0;
      #1;
      chk("rstrd.gnt", gnt, 1);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rstrd.busy", busy, 0);
      chk("rstrd.en", bEn, 0);
      chk("rstrd.addr", bAddr, 0);
      chk("rstrd.we", bWe, 0);
      chk("rstrd.wd", bWd, 0);
      chk("rstrd.rv", rv, 0);
      chk("rstrd.rd", rdD, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rvSeen = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         #1;
         if (rv || bEn) rvSeen++;
      end
      chk("rstrd.quiet", rvSeen, 0);

      // Read after reset release
      @(negedge clk);
      req = 1'b1; addr = 32'h10; wrEn = '0;
      #1;
      chk("rerd.gnt", gnt, 1);
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         req = 1'b0;
         #1;
         chk($sformatf("rerd%0d.rv", j), rv, (j == 6));
         if (j == 6) chk("rerd.rd", rdD, DATA_A);
      end

      // RD_LATENCY=3 instance: write a word at 0x0, then read it back
      @(negedge clk);
      req3 = 1'b1; addr3 = 32'h0; wrEn3 = 16'hFFFF; wrD3 = DATA_E;
      #1;
      chk("l3wr.gnt", gnt3, 1);
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         req3 = 1'b0; wrEn3 = '0;
      end
      @(negedge clk);
      req3 = 1'b1; addr3 = 32'h0; wrEn3 = '0;
      #1;
      chk("l3rd.gnt", gnt3, 1);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         req3 = 1'b0;
         #1;
         chk($sformatf("l3rd%0d.rv", j), rv3, (j == 8));
         if (j == 8) chk("l3rd.rd", rdD3, DATA_E);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
